// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
// The unit side uses the slave modport; the issuing side uses master.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_muldiv_op;
  logic [XLEN-1:0] i_operand_a;
  logic [XLEN-1:0] i_operand_b;
  logic            o_valid;
  logic [XLEN-1:0] o_muldiv_data;

  modport master (
    output i_valid, i_muldiv_op, i_operand_a, i_operand_b,
    input  o_ready, o_valid, o_muldiv_data
  );

  modport slave (
    input  i_valid, i_muldiv_op, i_operand_a, i_operand_b,
    output o_ready, o_valid, o_muldiv_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// one request in flight, fixed XLEN+2 edge latency (single edge for divide-by-zero fast path).
module muldiv_unit #(
  parameter int XLEN      = 32,
  parameter bit FAST_ZERO = 1'b1
) (
  input logic          i_clk,
  input logic          i_rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam int W2 = 2 * XLEN;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  function automatic logic [XLEN-1:0] negate_x(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  function automatic logic [W2-1:0] negate_2x(input logic [W2-1:0] v);
    return ~v + W2'(1);
  endfunction

  function automatic logic a_is_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] result_q;

  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] addend_q;
  logic [XLEN-1:0] rem_q;
  logic [W2-1:0]   acc_q;
  logic            neg_q;
  logic            neg_r_q;
  logic            div0_q;

  logic                   accept;
  logic                   in_div;
  logic                   b_zero;
  logic                   take_fast;
  logic                   last_iter;
  logic signed [XLEN-1:0] opa_s;
  logic signed [XLEN-1:0] opb_s;
  logic                   sign_a;
  logic                   sign_b;
  logic [XLEN-1:0]        mag_a;
  logic [XLEN-1:0]        mag_b;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic            div_ge;

  logic [W2-1:0]   prod;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] fix_result;

  assign accept    = (state_q == S_IDLE) && bus.i_valid;
  assign in_div    = bus.i_muldiv_op[2];
  assign b_zero    = (bus.i_operand_b == '0);
  assign take_fast = FAST_ZERO && in_div && b_zero;
  assign last_iter = (count_q == CW'(XLEN - 1));

  assign opa_s  = signed'(bus.i_operand_a);
  assign opb_s  = signed'(bus.i_operand_b);
  assign sign_a = a_is_signed(bus.i_muldiv_op) && (opa_s < 0);
  assign sign_b = b_is_signed(bus.i_muldiv_op) && (opb_s < 0);
  assign mag_a  = sign_a ? negate_x(bus.i_operand_a) : bus.i_operand_a;
  assign mag_b  = sign_b ? negate_x(bus.i_operand_b) : bus.i_operand_b;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          state_d = take_fast ? S_DONE : S_CALC;
        end
      end
      S_CALC:  state_d = last_iter ? S_FIX : S_CALC;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    bus.o_ready = 1'b0;
    bus.o_valid = 1'b0;
    unique case (state_q)
      S_IDLE:  bus.o_ready = 1'b1;
      S_DONE:  bus.o_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_muldiv_data = result_q;

  // Iteration counter and result register; both clear on reset so an aborted op leaves no trace
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q  <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          count_q <= '0;
          if (accept && take_fast) begin
            result_q <= bus.i_muldiv_op[1] ? bus.i_operand_a : '1;
          end
        end
        S_CALC:  count_q  <= last_iter ? '0 : count_q + CW'(1);
        S_FIX:   result_q <= fix_result;
        default: ;
      endcase
    end
  end

  // One iteration step: multiply adds the multiplicand under the multiplier LSB then shifts right;
  // divide shifts the next dividend bit into the partial remainder and trial-subtracts.
  assign mul_sum   = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, addend_q} : '0);
  assign div_shift = {rem_q, acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, addend_q};
  assign div_ge    = ~div_diff[XLEN];

  // Operand capture and datapath iteration
  always_ff @(posedge i_clk) begin
    if (accept) begin
      op_q    <= bus.i_muldiv_op;
      a_q     <= bus.i_operand_a;
      neg_q   <= sign_a ^ sign_b;
      neg_r_q <= sign_a;
      div0_q  <= in_div && b_zero;
      if (in_div) begin
        addend_q <= mag_b;
        acc_q    <= {{XLEN{1'b0}}, mag_a};
        rem_q    <= '0;
      end else begin
        addend_q <= mag_a;
        acc_q    <= {{XLEN{1'b0}}, mag_b};
      end
    end else if (state_q == S_CALC) begin
      if (op_q[2]) begin
        rem_q             <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        acc_q[XLEN-1:0]   <= {acc_q[XLEN-2:0], div_ge};
      end else begin
        acc_q <= {mul_sum, acc_q[XLEN-1:1]};
      end
    end
  end

  // Sign correction and result select; division by zero overrides the iterated values
  always_comb begin
    prod       = neg_q ? negate_2x(acc_q) : acc_q;
    quo        = neg_q ? negate_x(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_fix    = neg_r_q ? negate_x(rem_q) : rem_q;
    fix_result = '0;
    unique case (op_q)
      OP_MUL:                       fix_result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[W2-1:XLEN];
      OP_DIV, OP_DIVU:              fix_result = div0_q ? '1 : quo;
      OP_REM, OP_REMU:              fix_result = div0_q ? a_q : rem_fix;
      default:                      fix_result = '0;
    endcase
  end

endmodule
